matrix_op_sched: RTL
====================

MATRIX_OP_SCHED -- requirements
Module: matrix_op_sched

Interface
REQ-001 SHALL have parameters (name, default, meaning): ELEMENT_WIDTH, `ELEMENT_WIDTH, element bits; ADDR_WIDTH, `BRAM_ADDR_WIDTH, BRAM address bits; N_ENG, 4, engine count; TIMEOUT, 16'd20000, watchdog limit in cycles.
REQ-002 SHALL have ports (name direction width meaning): clk in 1 sole clock; rst in 1 synchronous active-high reset.
REQ-003 cmd_valid in 1, command offered; cmd_ready out 1, scheduler accepts; cmd_op in 3, opcode; cmd_dim_m/cmd_dim_n in 5 each, rows/cols of op1; cmd_addr_op1/op2/res in ADDR_WIDTH each, base addresses.
REQ-004 busy out 1, not idle; rsp_valid out 1, one-cycle completion pulse; rsp_err out 2, status code; rsp_cycles out 16, cycles spent in RUN.
REQ-005 eng_start out N_ENG, one-hot level start; eng_done in N_ENG, engine done levels; eng_dim_m/eng_dim_n out 5, eng_addr_op1/op2/res out ADDR_WIDTH, registered broadcast to all engines.
REQ-006 eng_rd_en in N_ENG; eng_rd_addr in N_ENG*ADDR_WIDTH; eng_wr_en in N_ENG; eng_wr_addr in N_ENG*ADDR_WIDTH; eng_wr_data in N_ENG*ELEMENT_WIDTH; slice k belongs to engine k.
REQ-007 mem_rd_en out 1; mem_rd_addr out ADDR_WIDTH; mem_wr_en out 1; mem_wr_addr out ADDR_WIDTH; mem_wr_data out ELEMENT_WIDTH; single BRAM port; mem_rd_data goes to engines directly, not through this block.

Function
REQ-008 Opcodes SHALL be OP_ADD=0, OP_MUL=1, OP_TRANSPOSE=2, OP_CONV=3, mapping to engine index; codes 4..7 invalid.
REQ-009 Error codes SHALL be ERR_OK=0, ERR_BAD_OP=1, ERR_BAD_DIM=2, ERR_TIMEOUT=3.
REQ-010 FSM states SHALL be IDLE, CHECK, RUN, RELEASE, RESP.
REQ-011 cmd_ready SHALL equal (state==IDLE); busy SHALL equal (state!=IDLE).
REQ-012 IDLE: on cmd_valid&&cmd_ready, latch op, dims, addresses into eng_* registers, go CHECK; cmd_valid while busy ignored, never queued.
REQ-013 CHECK (exactly one cycle): op>=N_ENG or op>3 -> err BAD_OP; else dim_m or dim_n outside 1..16 -> BAD_DIM; else OP_CONV with dim_m<3 or dim_n<3 -> BAD_DIM; error -> RESP, engine never started; valid -> RUN, sel<=op, rsp_cycles<=0.
REQ-014 RUN: eng_start[sel]=1 held continuously (level protocol), other bits 0; rsp_cycles increments each RUN cycle, saturating at 16'hFFFF.
REQ-015 RUN -> RELEASE when eng_done[sel]==1, err OK; eng_done of unselected engines ignored.
REQ-016 RUN -> RELEASE with err TIMEOUT when rsp_cycles reaches TIMEOUT before done; done same cycle wins (OK).
REQ-017 RELEASE: eng_start all 0; remain until eng_done[sel]==0, then RESP.
REQ-018 RESP: rsp_valid=1 for exactly one cycle with rsp_err, rsp_cycles stable; next state IDLE; rsp_err/rsp_cycles hold until next command accepted.
REQ-019 Memory mux: in RUN and RELEASE, mem_* SHALL equal engine sel slice combinationally (zero added latency); in all other states mem_rd_en=mem_wr_en=0, addresses/data 0.
REQ-020 Write from engine in the cycle it asserts done SHALL still reach mem_* (mux active in RUN).
REQ-021 Earliest accept after rsp_valid SHALL be the following cycle (IDLE).
REQ-022 Minimum valid-command latency: accept -> CHECK -> RUN(>=1) -> RELEASE(>=1) -> RESP.

Reset
REQ-023 On rst at a clock edge: state IDLE, eng_start=0, rsp_valid=0, rsp_err=0, rsp_cycles=0, eng_* registers 0, sel=0; mem_* outputs 0 from that cycle.
REQ-024 Reset mid-RUN SHALL drop eng_start immediately so engines return to idle via their own start-low path; no rsp_valid issued for the aborted command.

Structure
REQ-025 matrix_pkg.vh SHALL hold ELEMENT_WIDTH, BRAM_ADDR_WIDTH, opcode constants, error codes, N_ENG default.
REQ-026 FSM state encoding SHALL stay local to this module.
REQ-027 Memory mux SHALL be one sub-module, matrix_mem_mux (pure combinational, select + enable inputs).

Verification
REQ-028 ADD, m=n=4, stub engine done after 40 cycles -> eng_start=4'b0001 for 40 cycles, rsp_err=0, rsp_cycles=40, one rsp_valid.
REQ-029 CONV, m=2, n=5 -> rsp_err=2 two cycles after accept, eng_start never asserted, mem_wr_en stays 0.
REQ-030 op=5 -> rsp_err=1; op=3 m=n=16 with real conv engine -> 196 writes to addr_res..addr_res+195, rsp_err=0.
REQ-031 Stub never asserts done, TIMEOUT=100 -> rsp_err=3, rsp_cycles=100, eng_start low from RELEASE onward.
REQ-032 Unselected engine asserts rd_en/wr_en and done during RUN -> no effect on mem_*, state stays RUN.
REQ-033 rst pulsed mid-RUN, then second command -> all outputs 0 after reset edge, no rsp_valid, second command completes err 0.

Source files
------------

// File: rtl/matrix_op_sched_pkg.sv
// Shared widths, opcode/error encodings and the command legality check
// used by the matrix operation scheduler and its memory mux.
package matrix_op_sched_pkg;

    localparam int DEF_ELEMENT_WIDTH   = 16;
    localparam int DEF_BRAM_ADDR_WIDTH = 10;
    localparam int DEF_N_ENG           = 4;

    localparam int DIM_MIN      = 1;
    localparam int DIM_MAX      = 16;
    localparam int CONV_DIM_MIN = 3;

    typedef enum logic [2:0] {
        OP_ADD       = 3'd0,
        OP_MUL       = 3'd1,
        OP_TRANSPOSE = 3'd2,
        OP_CONV      = 3'd3
    } op_e;

    typedef enum logic [1:0] {
        ERR_OK      = 2'd0,
        ERR_BAD_OP  = 2'd1,
        ERR_BAD_DIM = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_e;

    function automatic logic dim_ok(input logic [4:0] d);
        return (d >= 5'(DIM_MIN)) && (d <= 5'(DIM_MAX));
    endfunction

    // Opcode is judged first, then the generic dimension range, then the
    // convolution kernel needing at least a 3x3 input.
    function automatic err_e cmd_check(
        input logic [2:0] op,
        input logic [4:0] dim_m,
        input logic [4:0] dim_n,
        input int         n_eng
    );
        if ((int'(op) >= n_eng) || (op > OP_CONV))
            return ERR_BAD_OP;
        if (!dim_ok(dim_m) || !dim_ok(dim_n))
            return ERR_BAD_DIM;
        if ((op == OP_CONV) && ((dim_m < 5'(CONV_DIM_MIN)) || (dim_n < 5'(CONV_DIM_MIN))))
            return ERR_BAD_DIM;
        return ERR_OK;
    endfunction

endpackage

// File: rtl/matrix_op_sched_mem_mux.sv
// Combinational BRAM port arbiter: forwards the selected engine's read/write
// request when enabled, otherwise drives an all-zero idle request.
module matrix_mem_mux
    import matrix_op_sched_pkg::*;
#(
    parameter int N_ENG      = DEF_N_ENG,
    parameter int ADDR_WIDTH = DEF_BRAM_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_ELEMENT_WIDTH,
    parameter int SEL_WIDTH  = 2
) (
    input  logic [SEL_WIDTH-1:0]          i_sel,
    input  logic                          i_en,
    input  logic [N_ENG-1:0]              i_rd_en,
    input  logic [N_ENG*ADDR_WIDTH-1:0]   i_rd_addr,
    input  logic [N_ENG-1:0]              i_wr_en,
    input  logic [N_ENG*ADDR_WIDTH-1:0]   i_wr_addr,
    input  logic [N_ENG*DATA_WIDTH-1:0]   i_wr_data,
    output logic                          o_rd_en,
    output logic [ADDR_WIDTH-1:0]         o_rd_addr,
    output logic                          o_wr_en,
    output logic [ADDR_WIDTH-1:0]         o_wr_addr,
    output logic [DATA_WIDTH-1:0]         o_wr_data
);

    always_comb begin
        o_rd_en   = 1'b0;
        o_rd_addr = '0;
        o_wr_en   = 1'b0;
        o_wr_addr = '0;
        o_wr_data = '0;
        if (i_en) begin
            o_rd_en   = i_rd_en[i_sel];
            o_rd_addr = i_rd_addr[int'(i_sel)*ADDR_WIDTH +: ADDR_WIDTH];
            o_wr_en   = i_wr_en[i_sel];
            o_wr_addr = i_wr_addr[int'(i_sel)*ADDR_WIDTH +: ADDR_WIDTH];
            o_wr_data = i_wr_data[int'(i_sel)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

endmodule

// File: rtl/matrix_op_sched.sv
// Single-command scheduler: validates a matrix command, runs one engine with a
// level start/done handshake under a watchdog, and reports a status pulse.
module matrix_op_sched
    import matrix_op_sched_pkg::*;
#(
    parameter int          ELEMENT_WIDTH = DEF_ELEMENT_WIDTH,
    parameter int          ADDR_WIDTH    = DEF_BRAM_ADDR_WIDTH,
    parameter int          N_ENG         = DEF_N_ENG,
    parameter logic [15:0] TIMEOUT       = 16'd20000
) (
    input  logic                            clk,
    input  logic                            rst,
    // Command: accepted on the cycle where cmd_valid and cmd_ready are both high;
    // cmd_ready is high only while idle, so nothing is ever queued.
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic [2:0]                      cmd_op,
    input  logic [4:0]                      cmd_dim_m,
    input  logic [4:0]                      cmd_dim_n,
    input  logic [ADDR_WIDTH-1:0]           cmd_addr_op1,
    input  logic [ADDR_WIDTH-1:0]           cmd_addr_op2,
    input  logic [ADDR_WIDTH-1:0]           cmd_addr_res,
    output logic                            busy,
    output logic                            rsp_valid,
    output logic [1:0]                      rsp_err,
    output logic [15:0]                     rsp_cycles,
    output logic [N_ENG-1:0]                eng_start,
    input  logic [N_ENG-1:0]                eng_done,
    output logic [4:0]                      eng_dim_m,
    output logic [4:0]                      eng_dim_n,
    output logic [ADDR_WIDTH-1:0]           eng_addr_op1,
    output logic [ADDR_WIDTH-1:0]           eng_addr_op2,
    output logic [ADDR_WIDTH-1:0]           eng_addr_res,
    input  logic [N_ENG-1:0]                eng_rd_en,
    input  logic [N_ENG*ADDR_WIDTH-1:0]     eng_rd_addr,
    input  logic [N_ENG-1:0]                eng_wr_en,
    input  logic [N_ENG*ADDR_WIDTH-1:0]     eng_wr_addr,
    input  logic [N_ENG*ELEMENT_WIDTH-1:0]  eng_wr_data,
    output logic                            mem_rd_en,
    output logic [ADDR_WIDTH-1:0]           mem_rd_addr,
    output logic                            mem_wr_en,
    output logic [ADDR_WIDTH-1:0]           mem_wr_addr,
    output logic [ELEMENT_WIDTH-1:0]        mem_wr_data,
    output logic [2:0]                      dbg_state
);

    localparam int SEL_W = (N_ENG > 1) ? $clog2(N_ENG) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CHECK   = 3'd1,
        S_RUN     = 3'd2,
        S_RELEASE = 3'd3,
        S_RESP    = 3'd4
    } state_e;

    state_e                  r_state;
    logic [2:0]              r_op;
    logic [SEL_W-1:0]        r_sel;
    logic [N_ENG-1:0]        r_eng_start;
    logic                    r_rsp_valid;
    logic [1:0]              r_rsp_err;
    logic [15:0]             r_rsp_cycles;
    logic [4:0]              r_dim_m;
    logic [4:0]              r_dim_n;
    logic [ADDR_WIDTH-1:0]   r_addr_op1;
    logic [ADDR_WIDTH-1:0]   r_addr_op2;
    logic [ADDR_WIDTH-1:0]   r_addr_res;

    logic                    w_sel_done;
    logic [15:0]             w_cyc_next;
    err_e                    w_check;
    logic                    w_mux_en;

    assign w_sel_done = eng_done[r_sel];
    assign w_cyc_next = (r_rsp_cycles == 16'hFFFF) ? r_rsp_cycles : r_rsp_cycles + 16'd1;
    assign w_check    = cmd_check(r_op, r_dim_m, r_dim_n, N_ENG);
    // The engine owns the BRAM port until it has dropped done, so a final
    // write issued alongside done still lands.
    assign w_mux_en   = (r_state == S_RUN) || (r_state == S_RELEASE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_op         <= '0;
            r_sel        <= '0;
            r_eng_start  <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_err    <= ERR_OK;
            r_rsp_cycles <= '0;
            r_dim_m      <= '0;
            r_dim_n      <= '0;
            r_addr_op1   <= '0;
            r_addr_op2   <= '0;
            r_addr_res   <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_op         <= cmd_op;
                        r_dim_m      <= cmd_dim_m;
                        r_dim_n      <= cmd_dim_n;
                        r_addr_op1   <= cmd_addr_op1;
                        r_addr_op2   <= cmd_addr_op2;
                        r_addr_res   <= cmd_addr_res;
                        r_rsp_err    <= ERR_OK;
                        r_rsp_cycles <= '0;
                        r_state      <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_check != ERR_OK) begin
                        r_rsp_err   <= w_check;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_sel        <= SEL_W'(r_op);
                        r_rsp_cycles <= '0;
                        r_eng_start  <= N_ENG'(1) << r_op;
                        r_state      <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_rsp_cycles <= w_cyc_next;
                    // Done in the same cycle as the watchdog expiry counts as success.
                    if (w_sel_done) begin
                        r_rsp_err   <= ERR_OK;
                        r_eng_start <= '0;
                        r_state     <= S_RELEASE;
                    end else if (w_cyc_next >= TIMEOUT) begin
                        r_rsp_err   <= ERR_TIMEOUT;
                        r_eng_start <= '0;
                        r_state     <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (!w_sel_done) begin
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_eng_start <= '0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    matrix_mem_mux #(
        .N_ENG      (N_ENG),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (ELEMENT_WIDTH),
        .SEL_WIDTH  (SEL_W)
    ) u_mem_mux (
        .i_sel     (r_sel),
        .i_en      (w_mux_en),
        .i_rd_en   (eng_rd_en),
        .i_rd_addr (eng_rd_addr),
        .i_wr_en   (eng_wr_en),
        .i_wr_addr (eng_wr_addr),
        .i_wr_data (eng_wr_data),
        .o_rd_en   (mem_rd_en),
        .o_rd_addr (mem_rd_addr),
        .o_wr_en   (mem_wr_en),
        .o_wr_addr (mem_wr_addr),
        .o_wr_data (mem_wr_data)
    );

    assign cmd_ready    = (r_state == S_IDLE);
    assign busy         = (r_state != S_IDLE);
    assign rsp_valid    = r_rsp_valid;
    assign rsp_err      = r_rsp_err;
    assign rsp_cycles   = r_rsp_cycles;
    assign eng_start    = r_eng_start;
    assign eng_dim_m    = r_dim_m;
    assign eng_dim_n    = r_dim_n;
    assign eng_addr_op1 = r_addr_op1;
    assign eng_addr_op2 = r_addr_op2;
    assign eng_addr_res = r_addr_res;
    assign dbg_state    = r_state;

endmodule
